// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped instruction cache that sits between the fetch stage and
//   the memory/bus model. Each line holds one aligned doubleword. A fetch
//   returns the 64-bit window starting at the (halfword-aligned) request
//   address. When that window straddles two doublewords, the cache does two
//   lookups (lo, then hi) and merges the results. Misses are refilled one at
//   a time through a rqst/done read port.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   icache_rqst    fetch request, sampled only in IDLE
//   icache_addr    fetch byte address (bit 0 ignored)
//   icache_done    one-cycle pulse, icache_data valid
//   icache_data    bytes addr..addr+7, little-endian, held until next done
//   fence_i        invalidate every line (deferred to IDLE when busy)
//   mem_rqst       one-cycle refill request pulse
//   mem_addr       8-byte aligned refill address, held until mem_done
//   mem_done       refill data valid pulse
//   mem_data       refill doubleword
module icache_responder #(
    parameter int NUM_LINES = 64,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_rqst,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_done,
    output logic [63:0]       icache_data,
    input  logic              fence_i,
    output logic              mem_rqst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [63:0]       mem_data
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int BASE_W = ADDR_W - 3;
    localparam int TAG_W  = BASE_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LK_LO,
        RF_LO,
        LK_HI,
        RF_HI,
        RESP
    } state_t;

    state_t              r_state;
    logic                r_fence_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_lo_word;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_LINES];
    logic [63:0]         r_data [NUM_LINES];

    logic                w_is_lo;
    logic                w_is_hi;
    logic                w_is_rf;
    logic [BASE_W-1:0]   w_base;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [2:0]          w_off;
    logic                w_hit;
    logic                w_got;
    logic                w_fill;
    logic [63:0]         w_word;

    // Selects the addr..addr+7 byte window out of the {hi, lo} pair.
    function automatic logic [63:0] f_merge(input logic [63:0] lo,
                                            input logic [63:0] hi,
                                            input logic [2:0]  off);
        return 64'({hi, lo} >> {off, 3'b000});
    endfunction

    assign w_is_lo = (r_state == LK_LO) || (r_state == RF_LO);
    assign w_is_hi = (r_state == LK_HI) || (r_state == RF_HI);
    assign w_is_rf = (r_state == RF_LO) || (r_state == RF_HI);

    // Doubleword index of the word being looked up; the +1 for the hi word
    // wraps naturally at the top of the address space.
    assign w_base = r_addr[ADDR_W-1:3] + BASE_W'(w_is_hi);
    assign w_idx  = w_base[IDX_W-1:0];
    assign w_tag  = w_base[BASE_W-1:IDX_W];
    assign w_off  = r_addr[2:0] & 3'b110;

    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill = w_is_rf && mem_done;
    // A refill completes the lookup exactly as a hit would.
    assign w_got  = ((r_state == LK_LO || r_state == LK_HI) && w_hit) || w_fill;
    assign w_word = w_is_rf ? mem_data : r_data[w_idx];

    // Control path: FSM, valid bits, fence bookkeeping and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fence_pend <= 1'b0;
            r_valid      <= '0;
            icache_done  <= 1'b0;
            icache_data  <= '0;
            mem_rqst     <= 1'b0;
            mem_addr     <= '0;
        end else begin
            icache_done <= 1'b0;
            mem_rqst    <= 1'b0;

            if (fence_i && r_state != IDLE) begin
                r_fence_pend <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    // Fence takes effect before a same-cycle request is looked up.
                    if (fence_i || r_fence_pend) begin
                        r_valid      <= '0;
                        r_fence_pend <= 1'b0;
                    end
                    if (icache_rqst) begin
                        r_state <= LK_LO;
                    end
                end

                LK_LO, RF_LO: begin
                    if (w_got) begin
                        if (w_fill) begin
                            r_valid[w_idx] <= 1'b1;
                        end
                        if (w_off == 3'b000) begin
                            icache_data <= w_word;
                            icache_done <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_state <= LK_HI;
                        end
                    end else if (r_state == LK_LO) begin
                        mem_rqst <= 1'b1;
                        mem_addr <= {w_base, 3'b000};
                        r_state  <= RF_LO;
                    end
                end

                LK_HI, RF_HI: begin
                    if (w_got) begin
                        if (w_fill) begin
                            r_valid[w_idx] <= 1'b1;
                        end
                        icache_data <= f_merge(r_lo_word, w_word, w_off);
                        icache_done <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_state == LK_HI) begin
                        mem_rqst <= 1'b1;
                        mem_addr <= {w_base, 3'b000};
                        r_state  <= RF_HI;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Data path: captured address, lo word and the line storage arrays.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && icache_rqst) begin
            r_addr <= icache_addr;
        end
        if (w_got && w_is_lo) begin
            r_lo_word <= w_word;
        end
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

    localparam int N     = 8;
    localparam int AW    = 64;
    localparam int TAG_SH = $clog2(N) + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_rqst;
    logic [AW-1:0] icache_addr;
    logic          icache_done;
    logic [63:0]   icache_data;
    logic          fence_i;
    logic          mem_rqst;
    logic [AW-1:0] mem_addr;
    logic          mem_done;
    logic [63:0]   mem_data;

    always #5 clk = ~clk;

    icache_responder #(.NUM_LINES(N), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .icache_rqst (icache_rqst),
        .icache_addr (icache_addr),
        .icache_done (icache_done),
        .icache_data (icache_data),
        .fence_i     (fence_i),
        .mem_rqst    (mem_rqst),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data)
    );

    int checks = 0;
    int errors = 0;
    int force_lat = -1;
    logic [63:0] addr_q[$];
    int          lat_q[$];
    logic [63:0] exp_refill[$];
    bit          mv[N];
    logic [63:0] mt[N];
    logic [63:0] last_data;

    function automatic logic [63:0] memword(input logic [63:0] a);
        if (a == 64'h400000) return 64'h1122334455667788;
        if (a == 64'h400008) return 64'h99AABBCCDDEEFF00;
        return (a * 64'h9E3779B97F4A7C15) ^ {a[31:0], ~a[63:32]};
    endfunction

    // Byte-by-byte view of memory: byte i of the result is memory byte addr+i.
    function automatic logic [63:0] expect_data(input logic [63:0] a);
        logic [63:0] r, b, x, w;
        b = {a[63:1], 1'b0};
        r = '0;
        for (int k = 0; k < 8; k++) begin
            x = b + 64'(k);
            w = memword({x[63:3], 3'b000});
            r[8*k +: 8] = w[8*x[2:0] +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
    endtask

    task automatic model_word(input logic [63:0] w);
        int idx;
        logic [63:0] tg;
        idx = int'((w >> 3) % N);
        tg  = w >> TAG_SH;
        if (!(mv[idx] && mt[idx] == tg)) begin
            exp_refill.push_back(w);
            mv[idx] = 1'b1;
            mt[idx] = tg;
        end
    endtask

    // Backing memory: answers each refill request after a chosen latency.
    initial begin
        mem_done = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_rqst === 1'b1) begin
                int l;
                logic [63:0] a;
                l = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                a = mem_addr;
                addr_q.push_back(a);
                lat_q.push_back(l);
                repeat (l) @(negedge clk);
                mem_data = memword(a);
                mem_done = 1'b1;
                @(negedge clk);
                mem_done = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [63:0] a, input bit extra, input bit fmode,
                         input bit fwith, input string tag);
        logic [63:0] b, lo, hi, edata;
        int n, elat, nref;
        bit fenced, got, mis;
        b   = {a[63:1], 1'b0};
        lo  = {b[63:3], 3'b000};
        hi  = lo + 64'd8;
        mis = (b[2:0] != 3'b000);
        if (fwith) model_clear();
        exp_refill.delete();
        addr_q.delete();
        lat_q.delete();
        model_word(lo);
        if (mis) model_word(hi);
        edata = expect_data(a);

        icache_addr = a;
        icache_rqst = 1'b1;
        fence_i     = fwith;
        n = 0; fenced = 0; got = 0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            icache_rqst = extra && (n == 1);
            if (extra && n == 1) icache_addr = ~a;
            fence_i = fmode && !fenced && (mem_rqst === 1'b1);
            if (fence_i) fenced = 1;
            if (icache_done === 1'b1) got = 1;
        end
        fence_i     = 1'b0;
        icache_rqst = 1'b0;
        chk({tag, ".done"}, 64'(got), 64'd1);
        if (got) begin
            last_data = icache_data;
            elat = 2 + (mis ? 1 : 0);
            foreach (lat_q[i]) elat += lat_q[i] + 1;
            chk({tag, ".lat"}, 64'(n), 64'(elat));
            chk({tag, ".data"}, icache_data, edata);
            chk({tag, ".nref"}, 64'(addr_q.size()), 64'(exp_refill.size()));
            nref = (addr_q.size() < exp_refill.size()) ? addr_q.size() : exp_refill.size();
            for (int i = 0; i < nref; i++) chk({tag, ".raddr"}, addr_q[i], exp_refill[i]);
        end
        @(negedge clk);
        chk({tag, ".nodup"}, 64'(icache_done), 64'd0);
        if (fenced) model_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w0, w1, a;
        int n;
        bit saw, sawdone;

        rst = 1'b1; icache_rqst = 1'b0; icache_addr = '0; fence_i = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst.done", 64'(icache_done), 64'd0);
        chk("rst.data", icache_data, 64'd0);
        chk("rst.mrqst", 64'(mem_rqst), 64'd0);
        chk("rst.maddr", mem_addr, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        force_lat = 3;
        fetch(64'h400000, 0, 0, 0, "cold");
        chk("cold.const", last_data, 64'h1122334455667788);
        fetch(64'h400000, 0, 0, 0, "rehit");
        force_lat = -1;

        fetch(64'h400008, 0, 0, 0, "fillhi");
        fetch(64'h400002, 0, 0, 0, "mis2hit");
        chk("mis2hit.const", last_data, 64'hFF00112233445566);

        fetch(64'h400048, 0, 0, 0, "evict");
        fetch(64'h400002, 0, 0, 0, "himiss");
        chk("himiss.const", last_data, 64'hFF00112233445566);
        fetch(64'h400008, 0, 0, 0, "hivalid");

        fetch(64'h400040, 0, 1, 0, "fencerf");
        fetch(64'h400040, 0, 0, 0, "postfence");
        fetch(64'h400040, 0, 0, 1, "fenceidle");

        fetch(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, "wrap");
        w0 = memword(64'h0);
        w1 = memword(64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap.const", last_data, {w0[47:0], w1[63:48]});

        fetch(64'h400000, 1, 0, 0, "busyrq");

        // Reset while the hi refill is outstanding; memory answers afterwards.
        fetch(64'h1000, 0, 0, 0, "prep_lo");
        fetch(64'h1048, 0, 0, 0, "prep_ev");
        force_lat = 3;
        icache_addr = 64'h1004;
        icache_rqst = 1'b1;
        n = 0; saw = 0;
        while (n < 50 && !saw) begin
            @(negedge clk);
            n++;
            icache_rqst = 1'b0;
            if (mem_rqst === 1'b1) saw = 1;
        end
        chk("rsthi.rqst", 64'(saw), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sawdone = 0;
        repeat (8) begin
            @(negedge clk);
            if (icache_done === 1'b1) sawdone = 1;
        end
        chk("rsthi.nodone", 64'(sawdone), 64'd0);
        chk("rsthi.data", icache_data, 64'd0);
        chk("rsthi.maddr", mem_addr, 64'd0);
        model_clear();
        force_lat = -1;
        fetch(64'h1000, 1, 0, 0, "afterrst");

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: a = 64'h400000;
                1: a = 64'h1000;
                default: a = 64'hFFFF_FFFF_FFFF_FF80;
            endcase
            a = a + 64'($urandom_range(0, 127)) * 64'd2;
            fetch(a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder for the pipeline's fetch port: it accepts `icache_rqst`/`icache_addr` and returns a 64-bit fetch window via `icache_done`/`icache_data`.
- Direct-mapped cache with one aligned doubleword per line; misses are refilled from a backing memory read port using the same rqst/done protocol.
- Halfword-aligned fetch addresses that straddle two doublewords are served by two lookups and merged.
- Sits between the fetch stage and the memory/bus model.

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2, at least 2. IDX_W = log2(NUM_LINES).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- icache_rqst  in  1  fetch request; sampled only in IDLE
- icache_addr  in  ADDR_W  fetch byte address; captured with rqst; bit 0 ignored (treated as 0)
- icache_done  out  1  single-cycle pulse; icache_data valid this cycle
- icache_data  out  64  little-endian bytes addr..addr+7; held until the next done
- fence_i  in  1  invalidate all lines
- mem_rqst  out  1  single-cycle refill request pulse
- mem_addr  out  ADDR_W  8-byte-aligned refill address; stable from rqst until mem_done
- mem_done  in  1  refill data valid pulse
- mem_data  in  64  refill doubleword

Behaviour:
- Address split:
  - off = addr[2:0]
  - idx = addr[3+:IDX_W]
  - tag = addr[ADDR_W-1:3+IDX_W]
  - lo = {addr[ADDR_W-1:3], 3'b0}
  - hi = lo + 8, which wraps modulo 2^ADDR_W (0xFFFF_FFFF_FFFF_FFF8 + 8 = 0).
- Storage per line: valid bit, tag, 64-bit data. All valid bits are cleared on reset.
- FSM states: IDLE, LK_LO, RF_LO, LK_HI, RF_HI, RESP.
  - IDLE: on icache_rqst, capture the address and go to LK_LO.
  - LK_LO: on hit, latch the lo word. If off==0, go to RESP; otherwise go to LK_HI. On miss, pulse mem_rqst with mem_addr=lo and go to RF_LO.
  - RF_LO: wait for mem_done, write the line (valid=1, tag, data), latch the lo word, then continue exactly as a lo hit would.
  - LK_HI / RF_HI: same as LK_LO / RF_LO using hi; on completion go to RESP.
  - RESP: icache_done=1 for one cycle; icache_data = ({hi_word, lo_word} >> 8*off)[63:0], or lo_word alone when off==0. Return to IDLE.
- Latency from the rqst cycle to the done cycle:
  - aligned hit: 2 cycles
  - misaligned, two hits: 3 cycles
  - each miss adds refill latency plus 1 cycle.
- Response rules:
  - Exactly one done per accepted request.
  - rqst outside IDLE is ignored.
  - rqst in the RESP cycle is ignored (the fetch stage never issues one there).
- Only one refill is outstanding at a time. mem_done outside RF_LO/RF_HI is ignored.
- fence_i:
  - In IDLE: clears all valid bits in that cycle. If rqst is simultaneous, the fence applies first and the request then misses.
  - Outside IDLE: recorded as pending and applied on the first cycle back in IDLE, before any new rqst is accepted that cycle.
  - A line refilled in the fenced transaction is still returned correctly to the requester.
- Reset mid-operation:
  - FSM returns to IDLE; icache_done, mem_rqst and pending fence are cleared; icache_data resets to 0; valid bits are cleared.
  - A late mem_done after reset is ignored.
- Reset values: icache_done=0, icache_data=0, mem_rqst=0, mem_addr=0.
- Lo/hi lookups always use different indices, so the hi refill never evicts the lo word of the same request.

Test Plan:
- Cold aligned miss: rqst addr=0x400000, memory returns 0x1122334455667788 after 3 cycles -> one mem_rqst with mem_addr=0x400000; done with data=0x1122334455667788. Re-request of the same address -> done 2 cycles after rqst, no mem_rqst.
- Misaligned, both cached: words at 0x400000=0x1122334455667788 and 0x400008=0x99AABBCCDDEEFF00; rqst addr=0x400002 -> done after 3 cycles with data=0xFF00112233445566.
- Misaligned, hi miss: same as above with 0x400008 uncached -> exactly one mem_rqst at 0x400008; same data; line 0x400008 valid afterwards.
- fence_i while in RF_LO, then re-request the same address -> current response correct; next request misses again (mem_rqst issued).
- Wrap: rqst addr=0xFFFF_FFFF_FFFF_FFFE -> refills at 0x...FFF8 and 0x0; data = {word@0[47:0], word@FFF8[63:48]}.
- Reset asserted during RF_HI, then mem_done pulses -> no icache_done; FSM in IDLE; next aligned rqst misses and completes normally; rqst while busy produces no extra done.
